// File: rtl/demux_dispatch_if.sv
// Handshake/bus bundle for demux_dispatch_ctrl. The cnt0/cnt1 members exist only
// when DISPATCH_COUNT_EN is defined.
interface demux_dispatch_if #(
  parameter int unsigned W = 4
);
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic         lane_ready0;
  logic         lane_ready1;
  logic         sel;
  logic [W-1:0] data_out;
  logic         out_valid0;
  logic         out_valid1;
  logic         empty;
`ifdef DISPATCH_COUNT_EN
  logic [7:0]   cnt0;
  logic [7:0]   cnt1;
`endif

  // Upstream producer / lane consumers side
  modport master (
    output in_data, in_valid, lane_ready0, lane_ready1,
    input  in_ready, sel, data_out, out_valid0, out_valid1, empty
`ifdef DISPATCH_COUNT_EN
    , input cnt0, cnt1
`endif
  );

  // Dispatch controller side
  modport slave (
    input  in_data, in_valid, lane_ready0, lane_ready1,
    output in_ready, sel, data_out, out_valid0, out_valid1, empty
`ifdef DISPATCH_COUNT_EN
    , output cnt0, cnt1
`endif
  );
endinterface

// File: rtl/demux_dispatch_ctrl.sv
// FIFO-buffered round-robin dispatcher feeding a 1-to-2 demux.
// Optional per-lane saturating dispatch counters: define DISPATCH_COUNT_EN.
module demux_dispatch_ctrl #(
  parameter int unsigned W     = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  demux_dispatch_if.slave  bus
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          rr_q, rr_d;
  logic          sel_q, sel_d;
  logic [W-1:0]  data_q, data_d;
  logic          ov0_q, ov0_d;
  logic          ov1_q, ov1_d;

  logic          full_c;
  logic          empty_c;
  logic          push_c;
  logic          pop_c;
  logic          target_c;
  logic [1:0]    lane_rdy_c;

`ifdef DISPATCH_COUNT_EN
  logic [7:0]    cnt0_q, cnt0_d;
  logic [7:0]    cnt1_q, cnt1_d;
`endif

  // Handshake decode and work-conserving lane choice
  always_comb begin
    full_c     = (count_q == CW'(DEPTH));
    empty_c    = (count_q == '0);
    lane_rdy_c = {bus.lane_ready1, bus.lane_ready0};
    push_c     = bus.in_valid && !full_c;
    pop_c      = !empty_c && (|lane_rdy_c);
    target_c   = lane_rdy_c[rr_q] ? rr_q : !rr_q;
  end

  // Next-state: pop reads the old head, so a same-cycle push never bypasses
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rr_d     = rr_q;
    sel_d    = sel_q;
    data_d   = data_q;
    ov0_d    = 1'b0;
    ov1_d    = 1'b0;

    if (push_c) begin
      mem_d[wr_ptr_q] = bus.in_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end

    if (pop_c) begin
      data_d   = mem_q[rd_ptr_q];
      sel_d    = target_c;
      ov0_d    = !target_c;
      ov1_d    = target_c;
      rd_ptr_d = rd_ptr_q + PW'(1);
      rr_d     = !target_c;
    end

    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rr_q     <= 1'b0;
      sel_q    <= 1'b0;
      data_q   <= '0;
      ov0_q    <= 1'b0;
      ov1_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rr_q     <= rr_d;
      sel_q    <= sel_d;
      data_q   <= data_d;
      ov0_q    <= ov0_d;
      ov1_q    <= ov1_d;
    end
  end

`ifdef DISPATCH_COUNT_EN
  // Per-lane dispatch counters, saturating at 255
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (pop_c && !target_c && (cnt0_q != 8'hFF)) cnt0_d = cnt0_q + 8'd1;
    if (pop_c &&  target_c && (cnt1_q != 8'hFF)) cnt1_d = cnt1_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign bus.cnt0 = cnt0_q;
  assign bus.cnt1 = cnt1_q;
`endif

  assign bus.in_ready   = !full_c;
  assign bus.empty      = empty_c;
  assign bus.sel        = sel_q;
  assign bus.data_out   = data_q;
  assign bus.out_valid0 = ov0_q;
  assign bus.out_valid1 = ov1_q;

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// Directed bench for demux_dispatch_ctrl: vector table plus hand-written
// sequences for full, simultaneous push/pop and mid-stream reset.
module tb_demux_dispatch_ctrl;
  localparam int unsigned W     = 4;
  localparam int unsigned DEPTH = 4;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  demux_dispatch_if #(.W(W)) bus_if ();

  demux_dispatch_ctrl #(.W(W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic [3:0] d;
    logic       l0;
    logic       l1;
    logic       e_sel;
    logic [3:0] e_data;
    logic       e_ov0;
    logic       e_ov1;
    logic       e_empty;
    logic       e_rdy;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic iv, input logic [3:0] d, input logic l0, input logic l1);
    bus_if.in_valid    = iv;
    bus_if.in_data     = d;
    bus_if.lane_ready0 = l0;
    bus_if.lane_ready1 = l1;
  endtask

  // Apply inputs, take one edge, sample 1 time unit later
  task automatic cycle(input logic iv, input logic [3:0] d, input logic l0, input logic l1);
    drive(iv, d, l0, l1);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input logic e_sel, input logic [3:0] e_data,
                         input logic e_ov0, input logic e_ov1, input logic e_empty,
                         input logic e_rdy);
    chk({name, ".sel"},      32'(bus_if.sel),        32'(e_sel));
    chk({name, ".data_out"}, 32'(bus_if.data_out),   32'(e_data));
    chk({name, ".ov0"},      32'(bus_if.out_valid0), 32'(e_ov0));
    chk({name, ".ov1"},      32'(bus_if.out_valid1), 32'(e_ov1));
    chk({name, ".empty"},    32'(bus_if.empty),      32'(e_empty));
    chk({name, ".in_ready"}, 32'(bus_if.in_ready),   32'(e_rdy));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    drive(1'b0, 4'h0, 1'b0, 1'b0);

    // Alternation then work-conserving skip; rr starts at 0
    vecs[0] = '{1'b1, 4'hF, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 4'h3, 1'b1, 1'b1, 1'b0, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 4'hA, 1'b1, 1'b1, 1'b1, 4'h3, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 4'h5, 1'b1, 1'b1, 1'b0, 4'hA, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 4'h5, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[5] = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 4'h5, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{1'b1, 4'h7, 1'b0, 1'b1, 1'b1, 4'h5, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 4'h7, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[8] = '{1'b1, 4'h2, 1'b1, 1'b1, 1'b1, 4'h7, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[9] = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 4'h2, 1'b1, 1'b0, 1'b1, 1'b1};

    // Reset asserted mid-cycle clears outputs without a clock edge
    #2 rst = 1'b1;
    #1;
    chk_out("reset", 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1);
`ifdef DISPATCH_COUNT_EN
    chk("reset.cnt0", 32'(bus_if.cnt0), 32'd0);
    chk("reset.cnt1", 32'(bus_if.cnt1), 32'd0);
`endif
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      cycle(vecs[i].iv, vecs[i].d, vecs[i].l0, vecs[i].l1);
      chk_out($sformatf("vec%0d", i), vecs[i].e_sel, vecs[i].e_data, vecs[i].e_ov0,
              vecs[i].e_ov1, vecs[i].e_empty, vecs[i].e_rdy);
    end

    // Back-pressure: fill with lanes stalled, 5th word held off
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, 4'(k + 1), 1'b0, 1'b0);
      chk($sformatf("fill%0d.in_ready", k), 32'(bus_if.in_ready), 32'(k < 3));
      chk($sformatf("fill%0d.no_strobe", k),
          32'(bus_if.out_valid0 | bus_if.out_valid1), 32'd0);
    end
    cycle(1'b1, 4'h5, 1'b0, 1'b0);
    chk("full_hold.in_ready", 32'(bus_if.in_ready), 32'd0);
    chk("full_hold.no_strobe", 32'(bus_if.out_valid0 | bus_if.out_valid1), 32'd0);
    // Only lane 1 ready: drain in order, word 5 enters after first pop
    for (int j = 0; j < 5; j++) begin
      cycle(j < 2, 4'h5, 1'b0, 1'b1);
      chk_out($sformatf("drain1_%0d", j), 1'b1, 4'(j + 1), 1'b0, 1'b1, j == 4, 1'b1);
    end
    cycle(1'b0, 4'h0, 1'b0, 1'b1);
    chk_out("drain1_idle", 1'b1, 4'h5, 1'b0, 1'b0, 1'b1, 1'b1);

    // Simultaneous push/pop with two words resident; rr is 0 here
    cycle(1'b1, 4'h1, 1'b0, 1'b0);
    cycle(1'b1, 4'h2, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 4'(i + 3), 1'b1, 1'b1);
      chk_out($sformatf("stream%0d", i), 1'(i % 2), 4'(i + 1), i % 2 == 0, i % 2 == 1,
              1'b0, 1'b1);
    end
    for (int i = 8; i < 10; i++) begin
      cycle(1'b0, 4'h0, 1'b1, 1'b1);
      chk_out($sformatf("stream%0d", i), 1'(i % 2), 4'(i + 1), i % 2 == 0, i % 2 == 1,
              i == 9, 1'b1);
    end
    cycle(1'b0, 4'h0, 1'b1, 1'b1);
    chk_out("stream_idle", 1'b1, 4'hA, 1'b0, 1'b0, 1'b1, 1'b1);

    // Mid-stream reset: 4 buffered, one dispatched (strobe high), 3 remain
    cycle(1'b1, 4'hB, 1'b0, 1'b0);
    cycle(1'b1, 4'hC, 1'b0, 1'b0);
    cycle(1'b1, 4'hD, 1'b0, 1'b0);
    cycle(1'b1, 4'hE, 1'b0, 1'b0);
    cycle(1'b0, 4'h0, 1'b1, 1'b1);
    chk_out("pre_rst", 1'b0, 4'hB, 1'b1, 1'b0, 1'b0, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk_out("mid_rst", 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1);
`ifdef DISPATCH_COUNT_EN
    chk("mid_rst.cnt0", 32'(bus_if.cnt0), 32'd0);
`endif
    #1 rst = 1'b0;
    cycle(1'b1, 4'h9, 1'b1, 1'b1);
    chk_out("post_rst_push", 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 4'h0, 1'b1, 1'b1);
    chk_out("post_rst_disp", 1'b0, 4'h9, 1'b1, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 4'h0, 1'b1, 1'b1);
    chk_out("post_rst_idle", 1'b0, 4'h9, 1'b0, 1'b0, 1'b1, 1'b1);
`ifdef DISPATCH_COUNT_EN
    chk("final.cnt0", 32'(bus_if.cnt0), 32'd1);
    chk("final.cnt1", 32'(bus_if.cnt1), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux_dispatch_ctrl.md
Name: demux_dispatch_ctrl

Overview:
Upstream control stage for the 1-to-2 data demultiplexer. It accepts a W-bit data stream over a valid/ready handshake and buffers it in a small FIFO. It then dispatches each word to one of two output lanes in round-robin order, driving the demux select and data inputs together with a one-cycle per-lane valid strobe. Lane back-pressure is honoured through per-lane ready inputs.

Parameters:
W, 4, data width; matches the demux data input width.
DEPTH, 4, FIFO entries; must be a power of two and at least 2.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
rst  input  1  asynchronous, active-high reset.
in_data  input  W  incoming data word.
in_valid  input  1  in_data is valid this cycle.
in_ready  output  1  FIFO can accept a word; combinational, equals !full.
lane_ready0  input  1  lane 0 consumer can take a word this cycle.
lane_ready1  input  1  lane 1 consumer can take a word this cycle.
sel  output  1  demux select; 0 = lane 0, 1 = lane 1; registered.
data_out  output  W  word presented to the demux data input; registered.
out_valid0  output  1  single-cycle strobe: data_out is valid for lane 0.
out_valid1  output  1  single-cycle strobe: data_out is valid for lane 1.
empty  output  1  FIFO holds no words; combinational from count.

Behaviour:
- Reset (asynchronous, active-high):
  - FIFO read pointer, write pointer and count clear to 0.
  - Round-robin pointer rr clears to 0.
  - sel = 0, data_out = 0, out_valid0 = 0, out_valid1 = 0.
  - After reset, empty = 1 and in_ready = 1.
- Reset mid-operation: buffered words are discarded and any strobe drops immediately. The first dispatch after reset goes to lane 0.
- Push: occurs when in_valid && in_ready at the clock edge. The word is written at wr_ptr, wr_ptr increments modulo DEPTH, and count increments.
- Full condition: count == DEPTH forces in_ready = 0. A same-cycle pop does not raise in_ready; there is no bypass.
- Dispatch condition, evaluated each cycle: !empty && (lane_ready0 || lane_ready1).
- Lane choice:
  - If lane_ready[rr] is set, target = rr; otherwise target = !rr. This is work-conserving.
  - The FIFO is never popped when neither lane is ready.
- On a dispatch edge:
  - data_out <= FIFO head; sel <= target.
  - out_valid[target] <= 1; out_valid[!target] <= 0.
  - rd_ptr increments modulo DEPTH, count decrements, rr <= !target.
- On a non-dispatch edge: both out_valid strobes go to 0. sel and data_out hold their last values.
- Simultaneous push and pop (not full): count is unchanged and both pointers advance. The word read is the old head, never the word being written.
- Ordering: words leave in strict FIFO order regardless of which lane takes them.
- Latency: a word accepted at edge N, with the FIFO previously empty and a lane ready, dispatches at edge N+1. out_valid is visible in the cycle after edge N+1, i.e. minimum 2 cycles from in_valid assertion to strobe.
- Throughput: one dispatch per cycle while words are buffered and at least one lane is ready.
- Count width: $clog2(DEPTH+1) bits. Pointer width: $clog2(DEPTH) bits, wrapping naturally.

Optional Feature:
DISPATCH_COUNT_EN:
- When defined, adds outputs cnt0 and cnt1, each 8 bits. Each is an 8-bit counter of words dispatched to lane 0 and lane 1 respectively.
- Both counters reset to 0, increment on the respective dispatch edge, and saturate at 255 (no wrap).
- When not defined, the ports and the logic are absent and the remaining behaviour is identical.

Test Plan:
1. Reset: assert rst mid-cycle -> outputs clear immediately: sel=0, data_out=0, out_valid0=0, out_valid1=0, empty=1, in_ready=1. With DISPATCH_COUNT_EN defined, cnt0 = cnt1 = 0.
2. Alternation: both lanes ready; push 4'hF, 4'h3, 4'hA, 4'h5 on consecutive cycles -> strobes alternate lane0, lane1, lane0, lane1 with data_out F, 3, A, 5 and sel 0, 1, 0, 1. The first strobe appears 2 cycles after the first in_valid.
3. Back-pressure/full: both lanes low; push 5 words -> in_ready falls after the 4th acceptance and the 5th word is held off. Raise lane_ready1 only -> all 4 words go to lane 1 (sel=1) in FIFO order, and in_ready rises the cycle after the first pop.
4. Work-conserving skip: rr=0, lane_ready0=0, lane_ready1=1, one word 4'h7 -> dispatched to lane 1. Next word with both lanes ready -> goes to lane 0.
5. Simultaneous push/pop: count=2, steady push with both lanes ready for 8 cycles -> count stays 2, output order matches input order, and there are no idle strobes.
6. Reset mid-stream: 3 words buffered, assert rst -> empty=1 and valids drop. After release, push 4'h9 -> delivered on lane 0.
